// File: rtl/pll_lock_supervisor.sv
// Power-up sequencer for the rPLL: pulses PLL reset, waits for a debounced lock, then releases sys_reset.
// Define PLL_LOCK_FILTER_EN to ignore lock-low glitches in RUN shorter than LOCK_DROP_CYC cycles.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3,
  parameter int LOCK_DROP_CYC    = 4
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart_req,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       pll_ok,
  output logic       fail,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  localparam int PW = $clog2(RST_PULSE_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE_CYC - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    RUN       = 3'd2,
    FAIL      = 3'd3
  } state_t;

  state_t        state;
  logic          lock_p0;
  logic          lock_s;
  logic          lock_loss;
  logic [PW-1:0] pulse_cnt;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] timer;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0 -> lock_s: two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= pll_lock;
      lock_s  <= lock_p0;
    end
  end

`ifdef PLL_LOCK_FILTER_EN
  localparam int DW = $clog2(LOCK_DROP_CYC + 1);
  localparam logic [DW-1:0] DROP_LAST = DW'(LOCK_DROP_CYC - 1);
  logic [DW-1:0] drop_cnt;

  assign lock_loss = !lock_s && (drop_cnt == DROP_LAST);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset)
      drop_cnt <= '0;
    else if (state != RUN || lock_s || restart_req || lock_loss)
      drop_cnt <= '0;
    else
      drop_cnt <= drop_cnt + 1'b1;
  end
`else
  assign lock_loss = !lock_s;
`endif

  assign state_o = state;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= RST_PLL;
      pll_reset  <= 1'b1;
      sys_reset  <= 1'b1;
      pll_ok     <= 1'b0;
      fail       <= 1'b0;
      retry_cnt  <= 8'd0;
      loss_cnt   <= 8'd0;
      pulse_cnt  <= '0;
      stable_cnt <= '0;
      timer      <= '0;
    end else begin
      // A loss in RUN is counted even when a restart request wins the transition
      if (state == RUN && lock_loss)
        loss_cnt <= sat_inc8(loss_cnt);

      if (restart_req) begin
        state      <= RST_PLL;
        pll_reset  <= 1'b1;
        sys_reset  <= 1'b1;
        pll_ok     <= 1'b0;
        fail       <= 1'b0;
        retry_cnt  <= 8'd0;
        pulse_cnt  <= '0;
        stable_cnt <= '0;
        timer      <= '0;
      end else begin
        case (state)
          RST_PLL: begin
            if (pulse_cnt == PULSE_LAST) begin
              state      <= WAIT_LOCK;
              pll_reset  <= 1'b0;
              pulse_cnt  <= '0;
              stable_cnt <= '0;
              timer      <= '0;
            end else begin
              pulse_cnt <= pulse_cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            timer      <= timer + 1'b1;
            stable_cnt <= lock_s ? stable_cnt + 1'b1 : '0;
            if (lock_s && stable_cnt == STABLE_LAST) begin
              state     <= RUN;
              sys_reset <= 1'b0;
              pll_ok    <= 1'b1;
              retry_cnt <= 8'd0;
            end else if (timer == TIMEOUT_LAST) begin
              retry_cnt <= retry_cnt + 8'd1;
              pll_reset <= 1'b1;
              pulse_cnt <= '0;
              if (retry_cnt + 8'd1 == 8'(MAX_RETRY)) begin
                state <= FAIL;
                fail  <= 1'b1;
              end else begin
                state <= RST_PLL;
              end
            end
          end
          RUN: begin
            if (lock_loss) begin
              state     <= RST_PLL;
              pll_reset <= 1'b1;
              sys_reset <= 1'b1;
              pll_ok    <= 1'b0;
              pulse_cnt <= '0;
            end
          end
          FAIL: begin
          end
          default: begin
            state     <= RST_PLL;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            pll_ok    <= 1'b0;
            fail      <= 1'b0;
            pulse_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus randomized lock patterns against a behavioural model.
module tb_pll_lock_supervisor;

  localparam int RSTP = 4;
  localparam int STAB = 8;
  localparam int TMO  = 32;
  localparam int MAXR = 2;
  localparam int DROP = 3;
`ifdef PLL_LOCK_FILTER_EN
  localparam int DROP_EFF = DROP;
`else
  localparam int DROP_EFF = 1;
`endif

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_reset;
  logic       sys_reset;
  logic       pll_ok;
  logic       fail;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_o;
  logic [22:0] obs;

  int total = 0;
  int bad = 0;
  int n;
  int sc_loss;

  // Reference model: state as int (0 reset-pulse, 1 wait, 2 run, 3 fail), time spent in state, run lengths
  int m_state, m_age, m_hi, m_low, m_retry, m_loss;
  bit lh0, lh1;

  pll_lock_supervisor #(
    .RST_PULSE_CYC(RSTP),
    .LOCK_STABLE_CYC(STAB),
    .LOCK_TIMEOUT_CYC(TMO),
    .MAX_RETRY(MAXR),
    .LOCK_DROP_CYC(DROP)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .pll_lock(pll_lock),
    .restart_req(restart_req),
    .pll_reset(pll_reset),
    .sys_reset(sys_reset),
    .pll_ok(pll_ok),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt),
    .state_o(state_o)
  );

  always #5 clkin = ~clkin;

  assign obs = {state_o, pll_reset, sys_reset, pll_ok, fail, retry_cnt, loss_cnt};

  task automatic model_reset();
    m_state = 0; m_age = 0; m_hi = 0; m_low = 0; m_retry = 0; m_loss = 0;
    lh0 = 1'b0; lh1 = 1'b0;
  endtask

  task automatic model_edge(input bit lk, input bit rq);
    bit ls;
    bit loss;
    ls  = lh1;
    lh1 = lh0;
    lh0 = lk;
    m_low = (m_state == 2 && !ls) ? m_low + 1 : 0;
    loss  = (m_state == 2) && (m_low >= DROP_EFF);
    if (loss) begin
      m_loss = (m_loss < 255) ? m_loss + 1 : 255;
      m_low  = 0;
    end
    if (rq) begin
      m_state = 0; m_age = 0; m_hi = 0; m_retry = 0; m_low = 0;
    end else begin
      case (m_state)
        0: begin
          m_age++;
          if (m_age == RSTP) begin m_state = 1; m_age = 0; m_hi = 0; end
        end
        1: begin
          m_age++;
          m_hi = ls ? m_hi + 1 : 0;
          if (m_hi == STAB) begin
            m_state = 2; m_retry = 0; m_age = 0;
          end else if (m_age == TMO) begin
            m_retry++;
            m_state = (m_retry == MAXR) ? 3 : 0;
            m_age = 0;
          end
        end
        2: if (loss) begin m_state = 0; m_age = 0; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [22:0] exp_vec();
    logic [2:0] s;
    s = 3'(m_state);
    return {s, (m_state == 0 || m_state == 3), (m_state != 2), (m_state == 2),
            (m_state == 3), 8'(m_retry), 8'(m_loss)};
  endfunction

  task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clkin);
    model_edge(pll_lock, restart_req);
    #1;
    check(tag, obs, exp_vec());
  endtask

  task automatic run(input logic lk, input int cnt, input string tag);
    pll_lock = lk;
    repeat (cnt) tick(tag);
  endtask

  task automatic restart(input string tag);
    restart_req = 1'b1;
    tick(tag);
    restart_req = 1'b0;
  endtask

  task automatic glitch(input int len, input string tag);
    run(1'b0, len, tag);
    run(1'b1, 24, tag);
    if (len >= DROP_EFF && sc_loss < 255) sc_loss++;
    check({tag, "_loss"}, 23'({state_o, loss_cnt}), 23'({3'd2, 8'(sc_loss)}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    sc_loss = 0;
    repeat (3) @(posedge clkin);
    #1;
    check("reset_vals", obs, {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    reset = 1'b0;

    // Normal bring-up
    n = 0;
    do begin tick("bringup"); n++; end while (pll_reset && n < 100);
    check("pll_reset_len", 23'(n), 23'd4);
    run(1'b0, 10, "wait_lock");
    pll_lock = 1'b1;
    n = 0;
    do begin tick("lock_rise"); n++; end while (sys_reset && n < 100);
    check("lock_to_run", 23'(n), 23'd10);
    check("run_outputs", 23'({pll_ok, state_o, retry_cnt}), 23'({1'b1, 3'd2, 8'd0}));

    // Lock-loss glitches of increasing length
    glitch(1, "glitch1");
    glitch(2, "glitch2");
    glitch(3, "glitch3");

    // Lock chatter during WAIT_LOCK
    pll_lock = 1'b0;
    restart("chatter_restart");
    run(1'b0, 4, "chatter_pulse");
    run(1'b1, 5, "chatter_hi");
    run(1'b0, 1, "chatter_lo");
    pll_lock = 1'b1;
    n = 0;
    do begin tick("chatter_rise"); n++; end while (!pll_ok && n < 100);
    check("chatter_to_run", 23'(n), 23'd10);

    // Timeout, retry, FAIL, restart
    pll_lock = 1'b0;
    restart("tmo_restart");
    run(1'b0, RSTP + TMO, "timeout1");
    check("retry1", 23'({retry_cnt, pll_reset, state_o}), 23'({8'd1, 1'b1, 3'd0}));
    run(1'b0, RSTP + TMO, "timeout2");
    check("fail_entry", 23'({fail, state_o, pll_reset, retry_cnt}), 23'({1'b1, 3'd3, 1'b1, 8'd2}));
    run(1'b0, 100, "fail_hold");
    check("fail_hold", 23'({fail, state_o, pll_reset, sys_reset, retry_cnt}),
          23'({1'b1, 3'd3, 1'b1, 1'b1, 8'd2}));
    restart("fail_restart");
    check("fail_exit", 23'({fail, state_o, retry_cnt, pll_reset}), 23'({1'b0, 3'd0, 8'd0, 1'b1}));

    // Randomized lock behaviour and occasional restarts
    for (int seg = 0; seg < 24; seg++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < 64; k++) begin
        case (mode)
          0: pll_lock = ($urandom_range(0, 99) < 95);
          1: pll_lock = 1'b0;
          default: pll_lock = ($urandom_range(0, 1) == 1);
        endcase
        restart_req = ($urandom_range(0, 249) == 0);
        tick("random");
      end
      restart_req = 1'b0;
    end

    // Asynchronous reset in the middle of WAIT_LOCK
    pll_lock = 1'b0;
    restart("midwait_restart");
    run(1'b0, RSTP + 20, "midwait");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", obs, {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    @(posedge clkin);
    #1;
    check("reset_hold", obs, exp_vec());
    reset = 1'b0;
    sc_loss = 0;

    // Loss counter saturation
    run(1'b1, 20, "sat_bringup");
    for (int i = 0; i < 260; i++) glitch(3, "sat");
    check("loss_saturated", 23'(loss_cnt), 23'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
